// File: rtl/spi_alu_slave.sv
// ----------------------------------------------------------------------------
// spi_alu_slave : SPI command responder with a 4-op ALU on the system clock
// Revision 1.0  : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module spi_alu_slave #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              nss,
  input  logic              mosi,
  output logic              miso,
  output logic              busy,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frames_done
);

  localparam int FRAME_W = 2 + 2 * DATA_W;
  localparam int RXC_W   = $clog2(FRAME_W);
  localparam int TXC_W   = $clog2(DATA_W);
  localparam logic [RXC_W-1:0] C_RX_LAST = RXC_W'(FRAME_W - 1);
  localparam logic [TXC_W-1:0] C_TX_LAST = TXC_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RX   = 3'd1,
    S_CALC = 3'd2,
    S_ARM  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t              r_state;
  logic [RXC_W-1:0]    r_rx_cnt;
  logic [TXC_W-1:0]    r_tx_cnt;
  logic [FRAME_W-1:0]  r_rx_shreg;
  logic [DATA_W-1:0]   r_tx_shreg;

  logic [1:0]          w_opcode;
  logic [DATA_W-1:0]   w_opa;
  logic [DATA_W-1:0]   w_opb;
  logic [DATA_W-1:0]   w_alu;

  // In CALC the receive register already holds the complete frame
  assign w_opcode = r_rx_shreg[FRAME_W-1 -: 2];
  assign w_opa    = r_rx_shreg[2*DATA_W-1 -: DATA_W];
  assign w_opb    = r_rx_shreg[DATA_W-1:0];

  always_comb begin
    w_alu = '0;
    case (w_opcode)
      2'b00:   w_alu = w_opa + w_opb;
      2'b01:   w_alu = w_opa - w_opb;
      2'b10:   w_alu = w_opa & w_opb;
      default: w_alu = w_opa | w_opb;
    endcase
  end

  assign miso = ((r_state == S_ARM) || (r_state == S_RESP)) ? r_tx_shreg[DATA_W-1] : 1'b0;
  assign busy = !((r_state == S_IDLE) || ((r_state == S_RX) && (r_rx_cnt == '0)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_rx_cnt     <= '0;
      r_tx_cnt     <= '0;
      r_rx_shreg   <= '0;
      r_tx_shreg   <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
      frames_done  <= '0;
    end else begin
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (nss) r_state <= S_RX;
        end
        S_RX: begin
          if (!nss) begin
            r_rx_shreg <= {r_rx_shreg[FRAME_W-2:0], mosi};
            if (r_rx_cnt == C_RX_LAST) begin
              r_rx_cnt     <= '0;
              result_valid <= 1'b1;
              r_state      <= S_CALC;
            end else begin
              r_rx_cnt <= r_rx_cnt + RXC_W'(1);
            end
          end else if (r_rx_cnt != '0) begin
            frame_err <= 1'b1;
            r_rx_cnt  <= '0;
          end
        end
        S_CALC: begin
          result     <= w_alu;
          r_tx_shreg <= w_alu;
          r_tx_cnt   <= '0;
          r_state    <= S_ARM;
        end
        S_ARM: begin
          if (nss) r_state <= S_RESP;
        end
        S_RESP: begin
          if (!nss) begin
            r_tx_shreg <= {r_tx_shreg[DATA_W-2:0], 1'b0};
            if (r_tx_cnt == C_TX_LAST) begin
              r_tx_cnt    <= '0;
              frames_done <= frames_done + CNT_W'(1);
              r_state     <= S_IDLE;
            end else begin
              r_tx_cnt <= r_tx_cnt + TXC_W'(1);
            end
          end else if (r_tx_cnt != '0) begin
            frame_err <= 1'b1;
            r_tx_cnt  <= '0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_alu_slave.sv
// ----------------------------------------------------------------------------
// tb_spi_alu_slave : randomized bench against an arithmetic reference model
// Revision 1.0     : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_spi_alu_slave;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              nss   = 1'b1;
  logic              mosi  = 1'b0;
  logic              miso;
  logic              busy;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              frame_err;
  logic [CNT_W-1:0]  frames_done;

  int checks   = 0;
  int errors   = 0;
  int rv_count = 0;
  int fe_count = 0;
  int exp_done = 0;

  spi_alu_slave #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .nss          (nss),
    .mosi         (mosi),
    .miso         (miso),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .frame_err    (frame_err),
    .frames_done  (frames_done)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (result_valid) rv_count++;
    if (frame_err)    fe_count++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  // abort_kind: 0 full response, 1 nss raised mid-response, 2 reset mid-response
  task automatic run_frame(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int resp_bits, input int abort_kind);
    logic [65:0] frame;
    logic [31:0] expv;
    logic [31:0] got;
    int          rv0;
    int          fe0;
    frame = {op, a, b};
    expv  = ref_alu(op, a, b);
    got   = '0;
    rv0   = rv_count;
    fe0   = fe_count;
    nss = 1'b1;
    tick();
    for (int i = 65; i >= 0; i--) begin
      nss  = 1'b0;
      mosi = frame[i];
      if (i == 20) check("miso_rx", 64'(miso), 64'd0);
      tick();
    end
    check("rv_calc", 64'(result_valid), 64'd1);
    check("miso_calc", 64'(miso), 64'd0);
    nss  = 1'b0;
    mosi = 1'($urandom);
    tick();
    check("result", 64'(result), 64'(expv));
    check("rv_low", 64'(result_valid), 64'd0);
    repeat ($urandom_range(0, 2)) begin
      nss  = 1'b0;
      mosi = 1'($urandom);
      tick();
    end
    nss = 1'b1;
    tick();
    check("busy_resp", 64'(busy), 64'd1);
    for (int i = 0; i < resp_bits; i++) begin
      nss = 1'b0;
      got = {got[30:0], miso};
      tick();
    end
    if (abort_kind == 0) begin
      exp_done = (exp_done + 1) % (1 << CNT_W);
      check("readback", 64'(got), 64'(expv));
      check("frames_done", 64'(frames_done), 64'(exp_done));
      check("busy_idle", 64'(busy), 64'd0);
      check("rv_once", 64'(rv_count - rv0), 64'd1);
      check("no_ferr", 64'(fe_count - fe0), 64'd0);
    end else if (abort_kind == 1) begin
      check("partial_rb", 64'(got), 64'(expv >> (32 - resp_bits)));
      nss = 1'b1;
      tick();
      check("ferr_resp", 64'(frame_err), 64'd1);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_miso", 64'(miso), 64'd0);
      check("done_hold", 64'(frames_done), 64'(exp_done));
      tick();
      check("ferr_once", 64'(fe_count - fe0), 64'd1);
    end else begin
      reset = 1'b0;
      #1;
      exp_done = 0;
      check("rst_miso", 64'(miso), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_done", 64'(frames_done), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
    end
  endtask

  initial begin
    int rv0;
    int fe0;
    reset = 1'b0;
    nss   = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_miso", 64'(miso), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_done", 64'(frames_done), 64'd0);
    check("reset_rv", 64'(result_valid), 64'd0);
    check("reset_ferr", 64'(frame_err), 64'd0);
    reset = 1'b1;

    run_frame(2'd0, 32'd5, 32'd7, 32, 0);
    run_frame(2'd1, 32'd3, 32'd5, 32, 0);
    run_frame(2'd0, 32'hFFFF_FFFF, 32'd1, 32, 0);
    run_frame(2'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32, 0);
    run_frame(2'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32, 0);

    // Receive abort after 40 bits, then a clean frame must still work
    rv0 = rv_count;
    fe0 = fe_count;
    nss = 1'b1;
    tick();
    for (int i = 0; i < 40; i++) begin
      nss  = 1'b0;
      mosi = 1'($urandom);
      tick();
    end
    nss = 1'b1;
    tick();
    check("ferr_rx", 64'(frame_err), 64'd1);
    check("rx_abort_busy", 64'(busy), 64'd0);
    tick();
    check("ferr_rx_pulse", 64'(frame_err), 64'd0);
    check("ferr_rx_once", 64'(fe_count - fe0), 64'd1);
    check("rx_abort_no_rv", 64'(rv_count - rv0), 64'd0);
    run_frame(2'd0, 32'd1, 32'd1, 32, 0);

    run_frame(2'($urandom), $urandom, $urandom, 10, 1);
    run_frame(2'($urandom), $urandom, $urandom, 5, 2);
    run_frame(2'd0, 32'd9, 32'd4, 32, 0);

    for (int n = 0; n < 10; n++) begin
      run_frame(2'($urandom), $urandom, $urandom, 32, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_alu_slave.md
Name: spi_alu_slave

Overview:
SPI responder and ALU at the far end of the processor's SPI link.
- Receives a 66-bit command frame {opcode[1:0], opa[31:0], opb[31:0]}, MSB first, while nss is low.
- Computes the 32-bit ALU result, then returns it MSB first on miso during the next nss-low window.
- Shares the system clock with the initiator; there is no separate SCK.

Parameters:
DATA_W, 32, operand and result width; frame length is 2+2*DATA_W bits.
CNT_W, 16, width of the frames_done counter.

Ports:
clock  input  1  system clock; all sampling on rising edge
reset  input  1  asynchronous, active-low
nss  input  1  slave select, active low
mosi  input  1  command data from initiator
miso  output  1  response data to initiator
busy  output  1  high in any state other than IDLE/RX with bit count 0
result  output  DATA_W  last computed ALU result; holds until the next CALC
result_valid  output  1  one-cycle pulse in the CALC cycle
frame_err  output  1  one-cycle pulse on any aborted frame or response
frames_done  output  CNT_W  count of completed responses; wraps to 0

Behaviour:
Reset (async, any state):
- State goes to IDLE. Bit counter, shift registers, result and frames_done clear to 0.
- miso, result_valid and frame_err go to 0.

"Low edge" means a rising clock edge at which nss is sampled 0.

States:
- IDLE: miso=0. On the first edge with nss=1, go to RX.
- RX: on each low edge, rx_shreg <= {rx_shreg[64:0], mosi}; rx_cnt++.
  - Edge with nss=1 and rx_cnt in 1..65: frame_err pulse, rx_cnt<=0, stay in RX.
  - On the low edge that captures bit 66 (rx_cnt==65): go to CALC. The full frame is {rx_shreg[64:0], mosi}.
- CALC (exactly 1 cycle): result <= op(opa,opb), result_valid=1; tx_shreg <= that result; go to ARM.
  - Opcode 00: ADD, mod 2^DATA_W.
  - Opcode 01: SUB (opa-opb), two's complement wrap.
  - Opcode 10: AND.
  - Opcode 11: OR.
  - Latency from last mosi bit to result_valid: 1 cycle.
- ARM: miso=tx_shreg[DATA_W-1]. Low edges are ignored, so extra mosi bits beyond 66 are discarded. On the first edge with nss=1, go to RESP.
- RESP: miso=tx_shreg[DATA_W-1], combinational from the register.
  - On each low edge: tx_shreg <<= 1; tx_cnt++. The initiator sampling at those edges receives result[31] down to result[0].
  - When the 32nd low edge completes (tx_cnt==31): frames_done++, go to IDLE.
  - Edge with nss=1 and tx_cnt in 1..31: frame_err pulse, go to IDLE; frames_done unchanged.
  - Edge with nss=1 and tx_cnt==0: stay in RESP.

Boundaries:
- nss toggling during CALC has no effect.
- frames_done wraps from 2^CNT_W-1 to 0.
- A new frame is never accepted before the response completes or aborts.
- miso is 0 in IDLE, RX and CALC.

Test Plan:
1. ADD: opcode 00, opa=5, opb=7; 66 low edges, nss high 1 cycle, 32 low edges -> result_valid pulse once; result=0x0000000C; miso bits read 0x0000000C; frames_done=1.
2. SUB wrap: opcode 01, opa=3, opb=5 -> result and readback 0xFFFFFFFE. ADD opa=0xFFFFFFFF, opb=1 -> 0x00000000.
3. AND/OR: opa=0xF0F0F0F0, opb=0xFF00FF00 -> AND gives 0xF000F000; OR gives 0xFFF0FFF0.
4. Abort: nss high after 40 mosi bits -> frame_err one cycle, no result_valid; a following full ADD 1+1 frame returns 0x00000002.
5. Response abort: nss high after 10 response bits -> frame_err pulse, frames_done unchanged, state IDLE, miso=0.
6. Reset mid-RESP: reset low for 1 cycle after 5 response bits -> miso=0, result=0, frames_done=0; the next full frame works normally.
